gpio_bus_regs: RTL and testbench

- Processor-side responder for the switch/LED GPIO block.
- Presents switch state, LED drive, and switch-change interrupt logic as a small memory-mapped register file on a valid/ready request/response bus.
- Upstream of the GPIO pad block: consumes its switch sample and drives its LED register input.
- Produces the single processor interrupt line from per-switch edge detection with mask and write-1-to-clear pending bits.

---
 rtl/gpio_bus_regs.sv | 120 ++++++++++++
 tb/tb_gpio_bus_regs.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_regs.sv
// Switch/LED GPIO register file on a valid/ready request/response bus; response one cycle
// after acceptance, one transaction in flight, requests stalled (req_ready low) until the response is taken.
module gpio_bus_regs #(
  parameter int          DATA_W   = 4,
  parameter logic [31:0] ID_VALUE = 32'h6770_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] led_out,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              irq
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state;
  logic [DATA_W-1:0] sw_m, sw_s, sw_p;
  logic [DATA_W-1:0] irq_mask, irq_pend, edge_cfg;
  logic [DATA_W-1:0] sw_event, pend_clr;
  logic              accept, wr;
  logic [31:0]       rd_data;
  logic              unused_wdata;

  assign unused_wdata = ^req_wdata[31:DATA_W];

  assign accept = req_valid && (state == IDLE);
  assign wr     = accept && req_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_m <= '0;
      sw_s <= '0;
      sw_p <= '0;
    end else begin
      sw_m <= sw_in;
      sw_s <= sw_m;
      sw_p <= sw_s;
    end
  end

  assign sw_event = (sw_s & ~sw_p) | (~sw_s & sw_p & edge_cfg);
  assign pend_clr = (wr && req_addr == 3'd3) ? req_wdata[DATA_W-1:0] : '0;

  // A clear and a new event on the same bit in one cycle leave the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out  <= '0;
      irq_mask <= '0;
      edge_cfg <= '0;
      irq_pend <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && req_addr == 3'd1) led_out  <= req_wdata[DATA_W-1:0];
      if (wr && req_addr == 3'd2) irq_mask <= req_wdata[DATA_W-1:0];
      if (wr && req_addr == 3'd4) edge_cfg <= req_wdata[DATA_W-1:0];
      irq_pend <= (irq_pend & ~pend_clr) | sw_event;
      irq      <= |(irq_pend & irq_mask);
    end
  end

  // Pending read includes events landing on the acceptance edge.
  always_comb begin
    rd_data = '0;
    case (req_addr)
      3'd0:    rd_data = 32'(sw_s);
      3'd1:    rd_data = 32'(led_out);
      3'd2:    rd_data = 32'(irq_mask);
      3'd3:    rd_data = 32'(irq_pend | sw_event);
      3'd4:    rd_data = 32'(edge_cfg);
      3'd5:    rd_data = ID_VALUE;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= RESP;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= req_we ? 32'd0 : rd_data;
            rsp_err   <= (req_addr >= 3'd6);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_regs.sv
// Bench for gpio_bus_regs: directed scenarios plus randomized traffic checked every cycle
// against a register-map model that tracks switch samples as a short history array.
module tb_gpio_bus_regs;
  localparam int          W  = 4;
  localparam logic [31:0] ID = 32'h6770_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  sw_in;
  logic [W-1:0]  led_out;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err, irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_bus_regs #(.DATA_W(W), .ID_VALUE(ID)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .led_out(led_out),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: h[0] newest switch sample; a switch value becomes visible
  // two edges after sampling, and an event compares it with the value before.
  logic [W-1:0] h [3];
  logic [W-1:0] m_led, m_mask, m_pend, m_ecfg, ev, clr;
  logic         m_irq, m_busy, m_err;
  logic [31:0]  m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) h[i] = '0;
      m_led = '0; m_mask = '0; m_pend = '0; m_ecfg = '0;
      m_irq = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_rdata = '0;
    end else begin
      ev    = (h[1] & ~h[2]) | (~h[1] & h[2] & m_ecfg);
      clr   = '0;
      m_irq = ((m_pend & m_mask) != '0);
      if (!m_busy && req_valid) begin
        m_busy  = 1'b1;
        m_err   = (req_addr >= 3'd6);
        m_rdata = '0;
        if (req_we) begin
          if (req_addr == 3'd1) m_led  = req_wdata[W-1:0];
          if (req_addr == 3'd2) m_mask = req_wdata[W-1:0];
          if (req_addr == 3'd3) clr    = req_wdata[W-1:0];
          if (req_addr == 3'd4) m_ecfg = req_wdata[W-1:0];
        end else begin
          case (req_addr)
            3'd0: m_rdata = 32'(h[1]);
            3'd1: m_rdata = 32'(m_led);
            3'd2: m_rdata = 32'(m_mask);
            3'd3: m_rdata = 32'(m_pend | ev);
            3'd4: m_rdata = 32'(m_ecfg);
            3'd5: m_rdata = ID;
            default: m_rdata = '0;
          endcase
        end
      end else if (m_busy && rsp_ready) begin
        m_busy = 1'b0;
      end
      m_pend = (m_pend & ~clr) | ev;
      h[2] = h[1];
      h[1] = h[0];
      h[0] = sw_in;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("led_out", 32'(led_out), 32'(m_led));
      check("irq", 32'(irq), 32'(m_irq));
      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy));
      if (m_busy) begin
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  // Accepts at the second rising edge after the call; returns #1 after the response handshake.
  task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rsp_latency", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata; er = rsp_err;
    n = 0;
    while (!(rsp_valid && rsp_ready) && n < 20) begin @(negedge clk); n++; end
    if (!(rsp_valid && rsp_ready)) check("rsp_timeout", 32'(rsp_valid && rsp_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    rst = 1'b1; sw_in = '0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(led_out), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    #2 rst = 1'b0;

    // ID and switch readback
    bus(1'b0, 3'd5, 32'd0, rd, er);
    check("id", rd, ID);
    check("id_err", 32'(er), 0);
    bus(1'b0, 3'd0, 32'd0, rd, er);
    check("sw_zero", rd, 0);

    // LED write, upper bits dropped
    bus(1'b1, 3'd1, 32'hFFFF_FFF5, rd, er);
    check("wr_rdata", rd, 0);
    check("led_now", 32'(led_out), 32'h5);
    bus(1'b0, 3'd1, 32'd0, rd, er);
    check("led_rb", rd, 32'h5);

    // Rising-edge interrupt through the mask, then W1C
    bus(1'b1, 3'd2, 32'h2, rd, er);
    bus(1'b1, 3'd4, 32'h0, rd, er);
    sw_in = 4'b0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("irq_pre", 32'(irq), 0);
    @(negedge clk);
    check("irq_set", 32'(irq), 1);
    bus(1'b0, 3'd3, 32'd0, rd, er);
    check("pend_rise", rd, 32'h2);
    sw_in = 4'b0000;
    repeat (5) @(posedge clk);
    bus(1'b0, 3'd3, 32'd0, rd, er);
    check("pend_nofall", rd, 32'h2);
    bus(1'b1, 3'd3, 32'h2, rd, er);
    check("irq_clr", 32'(irq), 0);

    // Both-edge config while masked, then set-wins collision
    bus(1'b1, 3'd2, 32'h0, rd, er);
    bus(1'b1, 3'd4, 32'h1, rd, er);
    sw_in = 4'b0001;
    repeat (2) @(posedge clk);
    sw_in = 4'b0000;
    repeat (5) @(posedge clk);
    bus(1'b0, 3'd3, 32'd0, rd, er);
    check("pend_both", rd, 32'h1);
    check("irq_masked", 32'(irq), 0);
    bus(1'b1, 3'd3, 32'h1, rd, er);
    bus(1'b0, 3'd3, 32'd0, rd, er);
    check("pend_cleared", rd, 32'h0);
    sw_in = 4'b0001;
    @(posedge clk); #1;
    bus(1'b1, 3'd3, 32'h1, rd, er);
    bus(1'b0, 3'd3, 32'd0, rd, er);
    check("set_wins", rd, 32'h1);

    // Response held off; second request must not be taken
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd1;
    @(negedge clk);
    check("hold_ready_pre", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 3'd2; req_wdata = 32'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_rdata", rsp_rdata, 32'h5);
      check("hold_ready", 32'(req_ready), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    bus(1'b0, 3'd2, 32'd0, rd, er);
    check("mask_untouched", rd, 32'h0);
    bus(1'b1, 3'd7, 32'hFFFF_FFFF, rd, er);
    check("unmapped_wr_err", 32'(er), 1);
    check("unmapped_wr_rd", rd, 0);
    bus(1'b0, 3'd7, 32'd0, rd, er);
    check("unmapped_rd_err", 32'(er), 1);
    check("unmapped_rd_rd", rd, 0);
    bus(1'b0, 3'd1, 32'd0, rd, er);
    check("led_after_unmapped", rd, 32'h5);

    // Reset during RESP
    bus(1'b1, 3'd2, 32'h1, rd, er);
    check("irq_before_rst", 32'(irq), 1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("resp_before_rst", 32'(rsp_valid), 1);
    #2 rst = 1'b1;
    sw_in = 4'b1000;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_led", 32'(led_out), 0);
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_req_ready", 32'(req_ready), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    rsp_ready = 1'b1;
    // switch held high through reset: event lands on the third edge
    @(posedge clk);
    bus(1'b0, 3'd3, 32'd0, rd, er);
    check("held_switch_event", rd, 32'h8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(5, 0) == 0) sw_in = sw_in ^ 4'(1 << $urandom_range(W - 1, 0));
      req_valid = 1'($urandom_range(1, 0));
      req_we    = 1'($urandom_range(1, 0));
      req_addr  = 3'($urandom_range(7, 0));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(3, 0) != 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
